float_div_seq: RTL and testbench

- Iterative IEEE-754 single-precision divider: out = num_1 / num_2.
- Companion to the pipelined float multiplier in the FP execution slot of the VLIW datapath.
- Multi-cycle, start/valid handshake; mantissa quotient via restoring division, one bit per cycle.
- Subnormals flushed to zero; specials handled before iteration.

---
 rtl/fp32_pkg.sv | 30 +++
 rtl/fdiv_mant_iter.sv | 45 ++++
 rtl/float_div_seq.sv | 176 +++++++++++++++++
 tb/tb_float_div_seq.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/fp32_pkg.sv
// Shared binary32 field definitions, constants, divider state encoding and
// the split unpacker used by the FP execution slot.
package fp32_pkg;

  localparam int EXP_W   = 8;
  localparam int MAN_W   = 23;
  localparam int FP_BIAS = 127;

  localparam logic [31:0]      FP_QNAN    = 32'h7FC0_0000;
  localparam logic [EXP_W-1:0] FP_INF_EXP = 8'hFF;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    DIV   = 3'd2,
    NORM  = 3'd3,
    DONE  = 3'd4
  } fdiv_state_t;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] expo;
    logic [MAN_W-1:0] man;
  } fp32_fields_t;

  function automatic fp32_fields_t fp32_split(input logic [31:0] x);
    return fp32_fields_t'(x);
  endfunction

endpackage

// File: rtl/fdiv_mant_iter.sv
// Restoring mantissa divider: one quotient bit per i_step, MSB first.
// i_load seeds the remainder with the dividend and clears the quotient.
module fdiv_mant_iter #(
  parameter int QBITS = 26
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_step,
  input  logic [23:0]      i_dividend,
  input  logic [23:0]      i_divisor,
  output logic [QBITS-1:0] o_quot,
  output logic             o_rem_nz
);

  logic [24:0]      r_rem;
  logic [23:0]      r_div;
  logic [QBITS-1:0] r_quot;

  logic             w_ge;
  logic [24:0]      w_sel;

  // Remainder stays below 2*divisor, so the post-shift value always fits 25 bits.
  assign w_ge  = (r_rem >= {1'b0, r_div});
  assign w_sel = w_ge ? (r_rem - {1'b0, r_div}) : r_rem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem  <= '0;
      r_div  <= '0;
      r_quot <= '0;
    end else if (i_load) begin
      r_rem  <= {1'b0, i_dividend};
      r_div  <= i_divisor;
      r_quot <= '0;
    end else if (i_step) begin
      r_rem  <= w_sel << 1;
      r_quot <= {r_quot[QBITS-2:0], w_ge};
    end
  end

  assign o_quot   = r_quot;
  assign o_rem_nz = |r_rem;

endmodule

// File: rtl/float_div_seq.sv
// Iterative binary32 divider (out = num_1 / num_2), subnormals flushed to zero.
// Define FDIV_ROUND_EN for round-to-nearest-even; default build truncates.
module float_div_seq
  import fp32_pkg::*;
#(
  parameter int EXP_BIAS = FP_BIAS,
  parameter int QBITS    = 26
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] num_1,
  input  logic [31:0] num_2,
  output logic        busy,
  output logic        out_valid,
  output logic [31:0] out
);

  fdiv_state_t       r_state;
  logic [31:0]       r_n1;
  logic [31:0]       r_n2;
  logic              r_sign;
  logic signed [9:0] r_exp;
  logic [4:0]        r_cnt;
  logic              r_busy;
  logic              r_valid;
  logic [31:0]       r_out;

  fp32_fields_t      w_a;
  fp32_fields_t      w_b;
  logic              w_sign;
  logic              w_a_zero, w_a_inf, w_a_nan;
  logic              w_b_zero, w_b_inf, w_b_nan;
  logic              w_is_nan, w_is_inf, w_is_zero;
  logic signed [9:0] w_exp_calc;
  logic              w_load, w_step;
  logic [QBITS-1:0]  w_quot;
  logic              w_rem_nz;
  logic signed [9:0] w_norm_exp;
  logic [22:0]       w_frac;
  logic              w_guard, w_sticky;
  logic [23:0]       w_rnd;
  logic signed [9:0] w_fin_exp;
  logic [31:0]       w_result;

  // Returns {carry_out, frac}; a carry leaves frac at zero.
  function automatic logic [23:0] round_frac(input logic [22:0] frac,
                                             input logic guard,
                                             input logic sticky);
    logic inc;
`ifdef FDIV_ROUND_EN
    inc = guard & (sticky | frac[0]);
`else
    logic unused_gs;
    unused_gs = guard | sticky;
    inc       = 1'b0;
`endif
    return {1'b0, frac} + {23'b0, inc};
  endfunction

  function automatic logic [31:0] pack_result(input logic sign,
                                              input logic signed [9:0] expo,
                                              input logic [22:0] frac);
    if (expo >= 10'sd255)    return {sign, FP_INF_EXP, 23'h0};
    else if (expo <= 10'sd0) return {sign, 31'h0};
    else                     return {sign, expo[7:0], frac};
  endfunction

  assign w_a    = fp32_split(r_n1);
  assign w_b    = fp32_split(r_n2);
  assign w_sign = w_a.sign ^ w_b.sign;

  assign w_a_zero = (w_a.expo == '0);
  assign w_b_zero = (w_b.expo == '0);
  assign w_a_inf  = (w_a.expo == FP_INF_EXP) && (w_a.man == '0);
  assign w_b_inf  = (w_b.expo == FP_INF_EXP) && (w_b.man == '0);
  assign w_a_nan  = (w_a.expo == FP_INF_EXP) && (w_a.man != '0);
  assign w_b_nan  = (w_b.expo == FP_INF_EXP) && (w_b.man != '0);

  assign w_is_nan  = w_a_nan | w_b_nan | (w_a_zero & w_b_zero) | (w_a_inf & w_b_inf);
  assign w_is_inf  = w_a_inf | w_b_zero;
  assign w_is_zero = w_a_zero | w_b_inf;

  assign w_exp_calc = $signed({2'b00, w_a.expo}) - $signed({2'b00, w_b.expo})
                    + $signed(10'(EXP_BIAS));

  assign w_load = (r_state == CHECK);
  assign w_step = (r_state == DIV);

  fdiv_mant_iter #(.QBITS(QBITS)) u_iter (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_step     (w_step),
    .i_dividend ({1'b1, w_a.man}),
    .i_divisor  ({1'b1, w_b.man}),
    .o_quot     (w_quot),
    .o_rem_nz   (w_rem_nz)
  );

  // Quotient lies in (0.5, 2): q[25] tells whether a one-bit left shift is needed.
  always_comb begin
    w_norm_exp = r_exp;
    w_frac     = w_quot[24:2];
    w_guard    = w_quot[1];
    w_sticky   = w_quot[0] | w_rem_nz;
    if (!w_quot[QBITS-1]) begin
      w_norm_exp = r_exp - 10'sd1;
      w_frac     = w_quot[23:1];
      w_guard    = w_quot[0];
      w_sticky   = w_rem_nz;
    end
  end

  assign w_rnd     = round_frac(w_frac, w_guard, w_sticky);
  assign w_fin_exp = w_norm_exp + $signed({9'b0, w_rnd[23]});
  assign w_result  = pack_result(r_sign, w_fin_exp, w_rnd[22:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_n1    <= '0;
      r_n2    <= '0;
      r_sign  <= 1'b0;
      r_exp   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_out   <= '0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_n1    <= num_1;
            r_n2    <= num_2;
            r_busy  <= 1'b1;
            r_state <= CHECK;
          end
        end
        CHECK: begin
          r_sign <= w_sign;
          r_exp  <= w_exp_calc;
          r_cnt  <= '0;
          if (w_is_nan || w_is_inf || w_is_zero) begin
            if (w_is_nan)      r_out <= FP_QNAN;
            else if (w_is_inf) r_out <= {w_sign, FP_INF_EXP, 23'h0};
            else               r_out <= {w_sign, 31'h0};
            r_busy  <= 1'b0;
            r_valid <= 1'b1;
            r_state <= DONE;
          end else begin
            r_state <= DIV;
          end
        end
        DIV: begin
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'(QBITS - 1)) r_state <= NORM;
        end
        NORM: begin
          r_out   <= w_result;
          r_busy  <= 1'b0;
          r_valid <= 1'b1;
          r_state <= DONE;
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign out_valid = r_valid;
  assign out       = r_out;

endmodule

// File: tb/tb_float_div_seq.sv
// Scoreboard bench for float_div_seq: directed operands with hand-computed
// quotients, latency and busy-length checks, ignored start and mid-op reset.
module tb_float_div_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] num_1 = 32'h0;
  logic [31:0] num_2 = 32'h0;
  logic        busy;
  logic        out_valid;
  logic [31:0] out;

  float_div_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .num_1     (num_1),
    .num_2     (num_2),
    .busy      (busy),
    .out_valid (out_valid),
    .out       (out)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] res;
    int          lat;
    int          busy_cyc;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   total    = 0;
  int   bad      = 0;
  int   edge_cnt = 0;
  int   done_cnt = 0;
  int   busy_run = 0;

  localparam int LAT_NORM  = 29;
  localparam int LAT_SPEC  = 2;
  localparam int BUSY_NORM = 28;
  localparam int BUSY_SPEC = 1;

`ifdef FDIV_ROUND_EN
  localparam logic [31:0] THIRD = 32'h3EAAAAAB;
`else
  localparam logic [31:0] THIRD = 32'h3EAAAAAA;
`endif

  always @(posedge clk) edge_cnt = edge_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Monitor: pops one expectation per out_valid pulse.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      busy_run = 0;
    end else begin
      if (busy) busy_run++;
      if (out_valid) begin
        if (sb.size() == 0) begin
          check("spurious_valid", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check({e.name, "_out"}, out, e.res);
          check({e.name, "_lat"}, 32'(edge_cnt - e.acc + 1), 32'(e.lat));
          check({e.name, "_busycyc"}, 32'(busy_run), 32'(e.busy_cyc));
          check({e.name, "_busylow"}, {31'b0, busy}, 32'd0);
        end
        busy_run = 0;
        done_cnt++;
      end
    end
  end

  task automatic issue(input string name, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] r, input bit special);
    exp_t e;
    @(negedge clk);
    num_1 = a;
    num_2 = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    e.name     = name;
    e.res      = r;
    e.lat      = special ? LAT_SPEC : LAT_NORM;
    e.busy_cyc = special ? BUSY_SPEC : BUSY_NORM;
    e.acc      = edge_cnt;
    sb.push_back(e);
  endtask

  task automatic wait_done(input string name);
    int base;
    bit seen;
    base = done_cnt;
    seen = 1'b0;
    for (int i = 0; i < 80 && !seen; i++) begin
      @(negedge clk);
      if (done_cnt != base) seen = 1'b1;
    end
    if (!seen) check({name, "_timeout"}, 32'd0, 32'd1);
    @(negedge clk);
  endtask

  task automatic run(input string name, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] r, input bit special);
    issue(name, a, b, r, special);
    wait_done(name);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_busy",  {31'b0, busy}, 32'd0);
    check("rst_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out",   out, 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run("6div2",     32'h40C00000, 32'h40000000, 32'h40400000, 1'b0);
    run("m6div2",    32'hC0C00000, 32'h40000000, 32'hC0400000, 1'b0);
    run("3div1p5",   32'h40400000, 32'h3FC00000, 32'h40000000, 1'b0);
    run("1div3",     32'h3F800000, 32'h40400000, THIRD,        1'b0);
    run("1div0",     32'h3F800000, 32'h00000000, 32'h7F800000, 1'b1);
    run("m1div0",    32'hBF800000, 32'h00000000, 32'hFF800000, 1'b1);
    run("0div0",     32'h00000000, 32'h00000000, 32'h7FC00000, 1'b1);
    run("0div5",     32'h00000000, 32'h40A00000, 32'h00000000, 1'b1);
    run("infdiv2",   32'h7F800000, 32'h40000000, 32'h7F800000, 1'b1);
    run("nandiv1",   32'h7FC12345, 32'h3F800000, 32'h7FC00000, 1'b1);
    run("1divinf",   32'h3F800000, 32'h7F800000, 32'h00000000, 1'b1);
    run("overflow",  32'h7F000000, 32'h3E800000, 32'h7F800000, 1'b0);
    run("underflow", 32'h00800000, 32'h7F000000, 32'h00000000, 1'b0);

    // start pulsed while busy must be dropped, not queued
    issue("busy_ign", 32'h40C00000, 32'h40000000, 32'h40400000, 1'b0);
    repeat (8) @(negedge clk);
    num_1 = 32'h3F800000;
    num_2 = 32'h00000000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("busy_ign");
    repeat (40) @(negedge clk);

    // leave a nonzero result on out, then abort a division mid-DIV
    run("pre_abort", 32'h3F800000, 32'h40400000, THIRD, 1'b0);
    @(negedge clk);
    num_1 = 32'h40C00000;
    num_2 = 32'h40000000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy",  {31'b0, busy}, 32'd0);
    check("abort_out",   out, 32'h0);
    check("abort_valid", {31'b0, out_valid}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    run("post_abort", 32'h40C00000, 32'h40000000, 32'h40400000, 1'b0);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
